// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode encoding, flag bit
// positions and the flag-update classification used by stage 2.
package alu_pkg;

  // Opcode encoding. Values 8..15 are illegal and flagged via err.
  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_XOR    = 4'd2,
    OP_RED    = 4'd3,
    OP_SLL    = 4'd4,
    OP_SRA    = 4'd5,
    OP_ROR    = 4'd6,
    OP_PADDSB = 4'd7
  } alu_op_e;

  // Bit positions inside the {V,N,Z} flag vector.
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;

  // Which flags an opcode is allowed to update: {upd_z, upd_nv}.
  function automatic logic [1:0] is_flag_op(input logic [3:0] op);
    logic [1:0] upd;
    case (op)
      OP_ADD, OP_SUB:           upd = 2'b11;
      OP_XOR, OP_SLL,
      OP_SRA, OP_ROR:           upd = 2'b10;
      default:                  upd = 2'b00;
    endcase
    return upd;
  endfunction

  // Opcodes 8..15 are outside the defined instruction set.
  function automatic logic is_illegal_op(input logic [3:0] op);
    return op[3];
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for the ALU: logical left, arithmetic right
// and rotate right. Any other mode passes the operand through unchanged.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0]         data_i,
  input  logic [$clog2(W)-1:0] amt_i,
  input  alu_op_e              mode_i,
  output logic [W-1:0]         data_o
);

  // Select the shift flavour; rotate is taken from a doubled operand so a
  // zero amount naturally yields the operand itself.
  // NOTE: every output of an always_comb gets a default before the case so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    data_o = data_i;
    case (mode_i)
      OP_SLL:  data_o = data_i << amt_i;
      OP_SRA:  data_o = $signed(data_i) >>> amt_i;
      OP_ROR:  data_o = W'({data_i, data_i} >> amt_i);
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides. Stage 1 captures
// the operands, the adder sum/overflow and the shifter output; stage 2
// captures the selected result, err and the flag values to commit. Flags
// commit only when a result is actually handed over downstream.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int W    = 16,
  parameter int LANE = 4,
  parameter bit SAT  = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   opcode,
  input  logic [W-1:0] op1,
  input  logic [W-1:0] op2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         err,
  output logic [2:0]   flags
);

  localparam int SHW    = $clog2(W);
  localparam int NBYTE  = W / 8;
  localparam int NLANES = W / LANE;

  localparam logic [W-1:0]    SMAX      = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]    SMIN      = {1'b1, {(W-1){1'b0}}};
  localparam logic [LANE-1:0] LANE_MAX  = {1'b0, {(LANE-1){1'b1}}};
  localparam logic [LANE-1:0] LANE_MIN  = {1'b1, {(LANE-1){1'b0}}};

  // Pipeline control
  logic rdy_en_q;
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s1_adv, s2_adv, in_fire, out_fire;

  // Stage 1 state
  logic [3:0]   s1_op_q;
  logic [W-1:0] s1_a_q, s1_b_q;
  logic [W-1:0] s1_sum_q, s1_sum_d;
  logic         s1_ovf_q, s1_ovf_d;
  logic [W-1:0] s1_shf_q, s1_shf_d;
  logic [W-1:0] add_b;

  // Stage 2 state
  logic [W-1:0] s2_res_q, s2_res_d;
  logic         s2_err_q, s2_err_d;
  logic [2:0]   s2_pend_q, s2_pend_d;
  logic [1:0]   s2_upd_q, s2_upd_d;
  logic [W-1:0] add_res, red_acc, pad_res;
  logic [LANE:0] lane_sum;

  // Architectural flags
  logic [2:0] flags_q, flags_d;

  // Handshake and stall decisions; flush blocks both acceptance and delivery.
  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = rdy_en_q && s1_adv && !flush;
    in_fire  = in_valid && in_ready;
    out_fire = s2_valid_q && out_ready && !flush;
  end

  // Next-state of the stage valids.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s2_adv) s2_valid_d = s1_valid_q;
      if (s1_adv) s1_valid_d = in_fire;
    end
  end

  // Control registers: ready enable comes up one cycle after reset release.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q   <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      rdy_en_q   <= 1'b1;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // Stage 1 arithmetic: shared adder (SUB = op1 + ~op2 + 1) and overflow.
  always_comb begin
    add_b    = (opcode == OP_SUB) ? ~op2 : op2;
    s1_sum_d = op1 + add_b + {{(W-1){1'b0}}, (opcode == OP_SUB)};
    s1_ovf_d = (op1[W-1] == add_b[W-1]) && (s1_sum_d[W-1] != op1[W-1]);
  end

  alu_shifter #(.W(W)) u_shifter (
    .data_i (op1),
    .amt_i  (op2[SHW-1:0]),
    .mode_i (alu_op_e'(opcode)),
    .data_o (s1_shf_d)
  );

  // Stage 1 capture on every accepted operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_op_q  <= '0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_sum_q <= '0;
      s1_ovf_q <= 1'b0;
      s1_shf_q <= '0;
    end else if (in_fire) begin
      s1_op_q  <= opcode;
      s1_a_q   <= op1;
      s1_b_q   <= op2;
      s1_sum_q <= s1_sum_d;
      s1_ovf_q <= s1_ovf_d;
      s1_shf_q <= s1_shf_d;
    end
  end

  // Stage 2 result select: saturation, byte reduction, lane adds, flags.
  always_comb begin
    red_acc  = '0;
    pad_res  = '0;
    lane_sum = '0;

    for (int i = 0; i < NBYTE; i++) begin
      red_acc = red_acc + W'($signed(s1_a_q[8*i +: 8]))
                        + W'($signed(s1_b_q[8*i +: 8]));
    end

    for (int l = 0; l < NLANES; l++) begin
      lane_sum = {s1_a_q[l*LANE+LANE-1], s1_a_q[l*LANE +: LANE]}
               + {s1_b_q[l*LANE+LANE-1], s1_b_q[l*LANE +: LANE]};
      if (lane_sum[LANE] != lane_sum[LANE-1])
        pad_res[l*LANE +: LANE] = lane_sum[LANE] ? LANE_MIN : LANE_MAX;
      else
        pad_res[l*LANE +: LANE] = lane_sum[LANE-1:0];
    end

    // On overflow both operands share op1's sign, which gives the clamp side.
    if (SAT && s1_ovf_q)
      add_res = s1_a_q[W-1] ? SMIN : SMAX;
    else
      add_res = s1_sum_q;

    s2_err_d = 1'b0;
    case (s1_op_q)
      OP_ADD, OP_SUB:         s2_res_d = add_res;
      OP_XOR:                 s2_res_d = s1_a_q ^ s1_b_q;
      OP_RED:                 s2_res_d = red_acc;
      OP_SLL, OP_SRA, OP_ROR: s2_res_d = s1_shf_q;
      OP_PADDSB:              s2_res_d = pad_res;
      default: begin
        s2_res_d = '0;
        s2_err_d = is_illegal_op(s1_op_q);
      end
    endcase

    s2_pend_d         = '0;
    s2_pend_d[FLAG_Z] = (s2_res_d == '0);
    s2_pend_d[FLAG_N] = s2_res_d[W-1];
    s2_pend_d[FLAG_V] = s1_ovf_q;
    s2_upd_d          = is_flag_op(s1_op_q);
  end

  // Stage 2 capture whenever stage 1 moves forward into it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_res_q  <= '0;
      s2_err_q  <= 1'b0;
      s2_pend_q <= '0;
      s2_upd_q  <= '0;
    end else if (s2_adv && s1_valid_q && !flush) begin
      s2_res_q  <= s2_res_d;
      s2_err_q  <= s2_err_d;
      s2_pend_q <= s2_pend_d;
      s2_upd_q  <= s2_upd_d;
    end
  end

  // Flag commit happens only on the output handshake.
  always_comb begin
    flags_d = flags_q;
    if (out_fire) begin
      if (s2_upd_q[1]) flags_d[FLAG_Z] = s2_pend_q[FLAG_Z];
      if (s2_upd_q[0]) begin
        flags_d[FLAG_N] = s2_pend_q[FLAG_N];
        flags_d[FLAG_V] = s2_pend_q[FLAG_V];
      end
    end
  end

  // Architectural flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign out_valid = s2_valid_q;
  assign result    = s2_res_q;
  assign err       = s2_err_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed table, hand-written pipeline
// sequences (latency, hold, stream, flush, reset) and a randomized run
// against a behavioural reference model.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W    = 16;
  localparam int LANE = 4;
  localparam bit SAT  = 1'b1;
  localparam int SHW  = $clog2(W);
  localparam longint MAXV = (longint'(1) << (W-1)) - 1;
  localparam longint MINV = -MAXV - 1;
  localparam int LMAX = (1 << (LANE-1)) - 1;
  localparam int LMIN = -LMAX - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   opcode = '0;
  logic [W-1:0] op1 = '0;
  logic [W-1:0] op2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         err;
  logic [2:0]   flags;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b, res;
    logic         err;
    logic [2:0]   flg;
  } vec_t;

  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] a, b;
  } txn_t;

  txn_t       q[$];
  logic [2:0] mdl_flags = '0;
  int         n_pushed = 0;
  vec_t       vecs[18];

  alu_pipe #(.W(W), .LANE(LANE), .SAT(SAT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .op1(op1), .op2(op2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .err(err), .flags(flags)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: arithmetic on plain integers, flags from the rules.
  function automatic void ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [2:0] fin, output logic [W-1:0] r,
                                  output logic e, output logic [2:0] fo);
    longint sa, sb, s, acc;
    int     sh, x;
    bit     ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[SHW-1:0]);
    r = '0; e = 1'b0; fo = fin;
    case (op)
      4'd0, 4'd1: begin
        s   = (op == 4'd0) ? sa + sb : sa - sb;
        ovf = (s > MAXV) || (s < MINV);
        if (ovf && SAT) s = (s > MAXV) ? MAXV : MINV;
        r  = W'(s);
        fo = {ovf, r[W-1], (r == '0)};
      end
      4'd2: begin r = a ^ b; fo[0] = (r == '0); end
      4'd3: begin
        acc = 0;
        for (int i = 0; i < W/8; i++)
          acc += longint'($signed(a[8*i +: 8])) + longint'($signed(b[8*i +: 8]));
        r = W'(acc);
      end
      4'd4: begin r = a << sh; fo[0] = (r == '0); end
      4'd5: begin r = W'(sa >>> sh); fo[0] = (r == '0); end
      4'd6: begin
        for (int i = 0; i < W; i++) r[i] = a[(i + sh) % W];
        fo[0] = (r == '0);
      end
      4'd7: begin
        for (int l = 0; l < W/LANE; l++) begin
          x = int'($signed(a[l*LANE +: LANE])) + int'($signed(b[l*LANE +: LANE]));
          if (x > LMAX) x = LMAX;
          if (x < LMIN) x = LMIN;
          r[l*LANE +: LANE] = LANE'(x);
        end
      end
      default: begin r = '0; e = 1'b1; end
    endcase
  endfunction

  // One directed vector through an empty pipe; flags checked after handshake.
  task automatic run_vec(input vec_t v, input int idx);
    bit got;
    @(negedge clk);
    in_valid = 1'b1; opcode = v.op; op1 = v.a; op2 = v.b; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    check($sformatf("vec%0d out_valid", idx), got, 1);
    check($sformatf("vec%0d result", idx), result, v.res);
    check($sformatf("vec%0d err", idx), err, v.err);
    @(posedge clk);
    @(negedge clk);
    check($sformatf("vec%0d flags", idx), flags, v.flg);
  endtask

  // One clock of scoreboarded traffic.
  task automatic step(input bit iv, input logic [3:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input bit ordy);
    logic [W-1:0] er;
    logic         ee;
    logic [2:0]   ef;
    txn_t         t;
    @(negedge clk);
    check("flags", flags, mdl_flags);
    in_valid = iv; opcode = op; op1 = a; op2 = b; out_ready = ordy;
    #1;
    check("in_ready", in_ready, (q.size() < 2) || ordy);
    if (q.size() == 0) begin
      check("out_valid idle", out_valid, 0);
    end else if (out_valid) begin
      t = q[0];
      ref_alu(t.op, t.a, t.b, mdl_flags, er, ee, ef);
      check("stream result", result, er);
      check("stream err", err, ee);
      if (ordy) begin
        void'(q.pop_front());
        mdl_flags = ef;
      end
    end
    if (iv && in_ready) begin
      q.push_back('{op: op, a: a, b: b});
      n_pushed++;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() != 0; k++) step(1'b0, 4'd0, '0, '0, 1'b1);
    check("drain empty", q.size(), 0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h0000;
      default: return W'($urandom());
    endcase
  endfunction

  initial begin
    vecs[0]  = '{4'h0, 16'h7FF0, 16'h0020, 16'h7FFF, 1'b0, 3'b100};
    vecs[1]  = '{4'hC, 16'h1111, 16'h2222, 16'h0000, 1'b1, 3'b100};
    vecs[2]  = '{4'h1, 16'h0005, 16'h0005, 16'h0000, 1'b0, 3'b001};
    vecs[3]  = '{4'h2, 16'h00FF, 16'h00FF, 16'h0000, 1'b0, 3'b001};
    vecs[4]  = '{4'h7, 16'h7777, 16'h1111, 16'h7777, 1'b0, 3'b001};
    vecs[5]  = '{4'h3, 16'h0102, 16'h0304, 16'h000A, 1'b0, 3'b001};
    vecs[6]  = '{4'h5, 16'h8000, 16'h000F, 16'hFFFF, 1'b0, 3'b000};
    vecs[7]  = '{4'h6, 16'h0001, 16'h0001, 16'h8000, 1'b0, 3'b000};
    vecs[8]  = '{4'h4, 16'h1234, 16'h0000, 16'h1234, 1'b0, 3'b000};
    vecs[9]  = '{4'h1, 16'h8000, 16'h0001, 16'h8000, 1'b0, 3'b110};
    vecs[10] = '{4'h7, 16'h8888, 16'h8888, 16'h8888, 1'b0, 3'b110};
    vecs[11] = '{4'h3, 16'hFFFF, 16'hFFFF, 16'hFFFC, 1'b0, 3'b110};
    vecs[12] = '{4'h2, 16'h1234, 16'h0000, 16'h1234, 1'b0, 3'b110};
    vecs[13] = '{4'h0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 3'b010};
    vecs[14] = '{4'hF, 16'h0000, 16'h0000, 16'h0000, 1'b1, 3'b010};
    vecs[15] = '{4'h6, 16'h8001, 16'h0004, 16'h1800, 1'b0, 3'b010};
    vecs[16] = '{4'h1, 16'h7FFF, 16'hFFFF, 16'h7FFF, 1'b0, 3'b100};
    vecs[17] = '{4'h4, 16'h0001, 16'h0013, 16'h0008, 1'b0, 3'b100};

    // Reset values, then ready one cycle after release.
    #1 rst_n = 1'b0;
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset result", result, 0);
    check("reset err", err, 0);
    check("reset flags", flags, 0);
    check("reset in_ready", in_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("in_ready before first edge", in_ready, 0);
    @(negedge clk);
    #1 check("in_ready after first edge", in_ready, 1);

    // Directed table.
    foreach (vecs[i]) run_vec(vecs[i], i);
    mdl_flags = vecs[17].flg;

    // Latency: visible after the second edge from the offer.
    @(negedge clk);
    in_valid = 1'b1; opcode = 4'h0; op1 = 16'h7FF0; op2 = 16'h0020; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("latency not early", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    #1 check("latency valid", out_valid, 1);
    check("latency result", result, 16'h7FFF);
    @(posedge clk);
    @(negedge clk);
    check("latency flags", flags, 3'b100);

    // Hold: XOR result stalls for three cycles, flags wait for handshake.
    in_valid = 1'b1; opcode = 4'h2; op1 = 16'h00FF; op2 = 16'h00FF; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk) in_valid = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("hold valid", out_valid, 1);
      check("hold result", result, 16'h0000);
      check("hold err", err, 0);
      check("hold flags", flags, 3'b100);
      @(posedge clk);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("hold flags after handshake", flags, 3'b101);
    check("hold delivered", out_valid, 0);
    mdl_flags = 3'b101;

    // Back-to-back stream of 8 ops with out_ready toggling.
    begin
      int start;
      start = n_pushed;
      for (int c = 0; c < 40 && (n_pushed - start) < 8; c++)
        step(1'b1, 4'(n_pushed - start), pick(), pick(), (c % 2) == 0);
      check("stream accepted", n_pushed - start, 8);
      drain();
    end

    // Flush with two ops in flight.
    step(1'b1, 4'h0, 16'h8000, 16'h8000, 1'b1);
    drain();
    step(1'b1, 4'h1, 16'h0005, 16'h0005, 1'b0);
    step(1'b1, 4'h0, 16'h7FFF, 16'h0001, 1'b0);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; opcode = 4'h2; out_ready = 1'b1;
    #1;
    check("flush in_ready", in_ready, 0);
    check("flush pre out_valid", out_valid, 1);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush out_valid", out_valid, 0);
    check("flush flags", flags, 3'b110);
    q.delete();
    for (int k = 0; k < 3; k++) step(1'b0, 4'd0, '0, '0, 1'b1);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), pick(), pick(),
           $urandom_range(0, 3) != 0);
    drain();

    // Reset pulse mid-stream.
    step(1'b1, 4'h0, 16'h8000, 16'h8000, 1'b1);
    drain();
    step(1'b1, 4'h2, 16'h1234, 16'h4321, 1'b0);
    step(1'b1, 4'h1, 16'h0003, 16'h0001, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midreset out_valid", out_valid, 0);
    check("midreset result", result, 0);
    check("midreset err", err, 0);
    check("midreset flags", flags, 0);
    check("midreset in_ready", in_ready, 0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    q.delete();
    mdl_flags = '0;
    #1 check("post reset in_ready low", in_ready, 0);
    step(1'b1, 4'h1, 16'h0009, 16'h0009, 1'b1);
    drain();
    step(1'b0, 4'd0, '0, '0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the single-cycle 16-bit datapath ALU.
- Executes ADD/SUB (saturating), XOR, RED, SLL, SRA, ROR and PADDSB at width W.
- Uses valid/ready handshakes on input and output and a registered flag set (V, N, Z) that updates only when a result is delivered.
- Sits between the decode/register-read stage and writeback; the branch unit consumes the flag outputs.

Parameters:
- W, 16, datapath width; multiple of 8, at least 16.
- LANE, 4, PADDSB lane width in bits; W must be a multiple of LANE.
- SAT, 1, 1 = ADD/SUB saturate to the signed range; 0 = wrap.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous; drops all in-flight operations
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid && in_ready
- opcode  in  4  0=ADD 1=SUB 2=XOR 3=RED 4=SLL 5=SRA 6=ROR 7=PADDSB; 8-15 illegal
- op1  in  W  operand 1
- op2  in  W  operand 2; shift amount is op2[$clog2(W)-1:0]
- out_valid  out  1  result available
- out_ready  in  1  result consumed when out_valid && out_ready
- result  out  W  result
- err  out  1  result corresponds to an illegal opcode
- flags  out  3  {V,N,Z}, registered

Behaviour:
- Reset (async, rst_n low): both stage valids = 0, out_valid=0, result=0, err=0, flags=3'b000. in_ready is 1 one cycle after rst_n deasserts.
- Stage 1 registers opcode, operands, adder sum/overflow and shifter output. Stage 2 registers the selected result, err and pending flag values.
- Latency: an op accepted at edge k presents out_valid at edge k+2 if out_ready is held high. Throughput is 1 op/cycle.
- Stall rules:
  - s2 advances when !s2_valid || out_ready.
  - s1 advances when !s1_valid || s2 advances.
  - in_ready = s1 advances (combinational from out_ready; no skid buffer).
- Hold: result, err and out_valid stay stable while out_valid && !out_ready.
- ADD/SUB:
  - SUB = op1 + ~op2 + 1.
  - Signed overflow with SAT=1 clamps to 0x7FFF / 0x8000 (generalised to W) and sets V.
  - With SAT=0 the result wraps and V still marks overflow.
- XOR: op1 ^ op2.
- RED: signed sum of all 2*W/8 bytes of op1 and op2, sign-extended to W.
- Shifts:
  - SLL: logical left.
  - SRA: arithmetic right.
  - ROR: rotate right.
  - Shift amount 0 returns op1 unchanged.
- PADDSB: independent signed LANE-bit adds per lane, each saturated to [-2^(LANE-1), 2^(LANE-1)-1]. No carry crosses lanes.
- Flag update occurs only on the output handshake edge:
  - Z updates for ADD, SUB, XOR, SLL, SRA, ROR (Z=1 iff result==0).
  - N and V update for ADD and SUB only. N = result MSB after saturation.
  - RED, PADDSB and illegal opcodes leave all flags unchanged.
- Illegal opcode: result=0, err=1, flags unchanged. The pipeline keeps flowing.
- flush:
  - Clears s1_valid and s2_valid at the next edge.
  - Flags do not update even if out_ready is high that cycle.
  - in_ready is forced 0 during flush, so no op is accepted that cycle.
- Reset mid-operation discards all in-flight ops immediately and returns flags to 0.

Decomposition:
- Shared package alu_pkg holds:
  - the opcode enum alu_op_e (4-bit, values above);
  - flag index constants FLAG_Z=0, FLAG_N=1, FLAG_V=2;
  - a function is_flag_op(op) returning {updZ, updNV}.
- One sub-module: alu_shifter (combinational, parametrised by W; mode SLL/SRA/ROR), instantiated in stage 1.
- Adder, RED and PADDSB logic live inline.

Test Plan:
- ADD 0x7FF0+0x0020, W=16, SAT=1, out_ready=1 -> result 0x7FFF at edge +2; flags V=1 N=0 Z=0 after handshake.
- SUB 0x0005-0x0005 -> result 0x0000, Z=1 N=0 V=0. Follow with XOR 0x00FF^0x00FF, out_ready=0 for 3 cycles -> result held stable, flags unchanged until the handshake, then Z=1.
- PADDSB 0x7777+0x1111 -> 0x7777 (every lane saturated), flags unchanged. RED op1=0x0102, op2=0x0304 -> 0x000A, flags unchanged.
- SRA 0x8000 by 15 -> 0xFFFF, Z=0. ROR 0x0001 by 1 -> 0x8000. SLL 0x1234 by 0 -> 0x1234.
- Back-to-back stream of 8 ops with out_ready toggling 1,0,1,0 -> no loss or duplication, results in order, in_ready drops exactly when both stages are full.
- Opcode 0xC -> err=1, result 0, flags kept.
- flush with two ops in flight -> out_valid=0 next cycle, flags unchanged.
- rst_n pulse mid-stream -> all outputs zero asynchronously.
